clk_div_multi: RTL and testbench

Parametrised multi-output clock generator driven by the 50 MHz board reference. It produces NUM_CLOCKS divided clocks, with a matching single-cycle enable per output. Each output has its own divide ratio and phase offset, and both can be reprogrammed at run time through a valid/ready port. It sits beside the vendor PLL wrapper: it covers the low-rate clocks and clock enables the PLL does not provide, and it reports `locked` the same way.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_channel.sv | 65 ++++++
 rtl/clk_div_multi.sv | 104 ++++++++++
 tb/tb_clk_div_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-output clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ALIGN,
    SETTLE,
    LOCKED
  } state_e;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: stored ratio/phase, free-running counter, registered clock and enable.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_phase,
  input  logic             load,
  input  logic             blank,
  output logic             outclk,
  output logic             outclk_en
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic             en_q, en_d;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (wr_en) begin
      div_d   = (wr_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : wr_div;
      phase_d = (wr_phase < div_d) ? wr_phase : '0;
    end

    if (load) begin
      cnt_d = phase_q;
    end else if (cnt_q == div_q - CNT_W'(1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Decode from the next count so the outputs are registered without extra lag.
    outclk_d = !blank && (cnt_d < (div_q >> 1));
    en_d     = !blank && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= CNT_W'(DIV_INIT);
      phase_q  <= '0;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      en_q     <= en_d;
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = en_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-output clock/enable generator: control FSM, lock counter and config write decode.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_W       = 16,
  parameter int DIV_INIT    = 5,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [LK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;
  logic                armed_q, armed_d;
  logic                accept;
  logic                in_range;
  logic [NUM_CLOCKS-1:0] wr_en;
  logic                load;
  logic                blank;

  assign accept   = cfg_valid && locked_q;
  assign in_range = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CLOCKS);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    // Cleared by reset so the first ALIGN after release lasts a full cycle.
    armed_d    = 1'b1;
    case (state_q)
      ALIGN: begin
        lock_cnt_d = '0;
        if (armed_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (lock_cnt_q == LK_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
        else lock_cnt_d = lock_cnt_q + LK_W'(1);
      end
      LOCKED: begin
        if (accept && in_range) state_d = ALIGN;
      end
      default: state_d = ALIGN;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      wr_en[i] = accept && in_range && (cfg_ch == CH_W'(i));
    end
  end

  assign load  = (state_q == ALIGN);
  assign blank = (state_d == ALIGN);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= ALIGN;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      armed_q    <= armed_d;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .DIV_INIT(DIV_INIT)
    ) u_ch (
      .clk      (refclk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .load     (load),
      .blank    (blank),
      .outclk   (outclk[i]),
      .outclk_en(outclk_en[i])
    );
  end

  assign locked    = locked_q;
  assign cfg_ready = locked_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: config vector table plus reset/handshake sequences.
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int LC  = 16;

  logic            refclk;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [15:0]     cfg_div;
  logic [15:0]     cfg_phase;
  logic [NCH-1:0]  outclk;
  logic [NCH-1:0]  outclk_en;
  logic            locked;

  int tests = 0;
  int fails = 0;
  int exp_div [NCH];
  int exp_ph  [NCH];

  typedef struct {
    int ch;
    int div_in;
    int ph_in;
    int div_eff;
    int ph_eff;
  } vec_t;

  vec_t vecs [6];

  clk_div_multi #(
    .NUM_CLOCKS (NCH),
    .CNT_W      (16),
    .DIV_INIT   (5),
    .LOCK_CYCLES(LC)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    for (int i = 0; i < NCH; i++) begin
      exp_div[i] = 5;
      exp_ph[i]  = 0;
    end
  endtask

  task automatic check_cycle(input string tag, input int t);
    logic [NCH-1:0] ec;
    logic [NCH-1:0] ee;
    int v;
    for (int i = 0; i < NCH; i++) begin
      v     = (exp_ph[i] + t) % exp_div[i];
      ec[i] = (v < exp_div[i] / 2);
      ee[i] = (v == 0);
    end
    chk($sformatf("%s_clk_t%0d", tag, t), 32'(outclk), 32'(ec));
    chk($sformatf("%s_en_t%0d", tag, t), 32'(outclk_en), 32'(ee));
    chk($sformatf("%s_lock_t%0d", tag, t), 32'(locked), 32'(t >= LC));
    chk($sformatf("%s_rdy_t%0d", tag, t), 32'(cfg_ready), 32'(t >= LC));
  endtask

  task automatic check_align(input string tag);
    chk({tag, "_align_clk"}, 32'(outclk), 32'(0));
    chk({tag, "_align_en"}, 32'(outclk_en), 32'(0));
    chk({tag, "_align_lock"}, 32'(locked), 32'(0));
    chk({tag, "_align_rdy"}, 32'(cfg_ready), 32'(0));
  endtask

  // Entered with rst high at a sample point; runs release through t = LC.
  task automatic release_reset(input string tag);
    set_defaults();
    rst = 1'b0;
    tick();
    check_align(tag);
    for (int t = 0; t <= LC; t++) begin
      tick();
      check_cycle(tag, t);
    end
  endtask

  // Leaves the bench one sample point after the accepting edge.
  task automatic do_write(input int ch, input int dv, input int ph);
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(dv);
    cfg_phase = 16'(ph);
    cfg_valid = 1'b1;
    for (int n = 0; n < 64 && cfg_ready !== 1'b1; n++) tick();
    if (cfg_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wr_timeout: got cfg_ready %b expected 1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ch: 1, div_in: 4, ph_in: 1, div_eff: 4, ph_eff: 1};
    vecs[1] = '{ch: 0, div_in: 0, ph_in: 0, div_eff: 2, ph_eff: 0};
    vecs[2] = '{ch: 2, div_in: 6, ph_in: 9, div_eff: 6, ph_eff: 0};
    vecs[3] = '{ch: 0, div_in: 1, ph_in: 1, div_eff: 2, ph_eff: 1};
    vecs[4] = '{ch: 2, div_in: 7, ph_in: 7, div_eff: 7, ph_eff: 0};
    vecs[5] = '{ch: 1, div_in: 3, ph_in: 2, div_eff: 3, ph_eff: 2};

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    repeat (3) tick();
    chk("rst_clk", 32'(outclk), 32'(0));
    chk("rst_lock", 32'(locked), 32'(0));

    release_reset("rel");

    for (int k = 0; k < 6; k++) begin
      do_write(vecs[k].ch, vecs[k].div_in, vecs[k].ph_in);
      check_align($sformatf("vec%0d", k));
      exp_div[vecs[k].ch] = vecs[k].div_eff;
      exp_ph[vecs[k].ch]  = vecs[k].ph_eff;
      for (int t = 0; t < 20; t++) begin
        tick();
        check_cycle($sformatf("vec%0d", k), t);
      end
    end

    // Out-of-range channel at t=19: accepted, nothing disturbed.
    cfg_ch    = 2'd3;
    cfg_div   = 16'd9;
    cfg_phase = 16'd1;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int t = 20; t < 30; t++) begin
      if (t > 20) tick();
      check_cycle("oor", t);
    end

    // Reset during SETTLE after a reprogram.
    do_write(1, 4, 1);
    check_align("mid");
    exp_div[1] = 4;
    exp_ph[1]  = 1;
    for (int t = 0; t < 5; t++) begin
      tick();
      check_cycle("mid", t);
    end
    rst = 1'b1;
    tick();
    check_align("mid_rst");
    tick();
    release_reset("mid_rel");

    // Reset coincident with a transfer: transfer discarded.
    rst       = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd8;
    cfg_phase = 16'd3;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_align("coinc_rst");
    release_reset("coinc");

    // Request held from reset: blocked until first locked cycle.
    rst       = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd4;
    cfg_phase = 16'd0;
    cfg_valid = 1'b1;
    tick();
    release_reset("hs");
    tick();
    cfg_valid = 1'b0;
    check_align("hs_acc");
    exp_div[0] = 4;
    exp_ph[0]  = 0;
    for (int t = 0; t <= LC; t++) begin
      tick();
      check_cycle("hs_run", t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
